// File: rtl/fso_pkg.sv
// ----------------------------------------------------------------------------
// fso_pkg
// Shared definitions for the FSO payload frame buffer:
//   - wr_state_t : write-side FSM encoding (HUNT / FILL / WAIT)
//   - rd_state_t : read-side FSM encoding (IDLE / DRAIN)
//   - TUSER_*    : bit positions inside the 2-bit AXIS tuser field
// ----------------------------------------------------------------------------
package fso_pkg;

   typedef enum logic [1:0] {
      WR_HUNT = 2'd0,   // waiting for a frame_start word
      WR_FILL = 2'd1,   // collecting the remaining words of a frame
      WR_WAIT = 2'd2    // both banks FULL, input stalled
   } wr_state_t;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_t;

   localparam int TUSER_BLK_RST = 0;
   localparam int TUSER_SOF     = 1;

endpackage : fso_pkg

// File: rtl/fso_framebuf_stats.sv
// ----------------------------------------------------------------------------
// fso_framebuf_stats
// Three free-running, wrapping 32-bit statistics counters for the frame buffer.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   i_frame_out          : one frame fully emitted this cycle
//   i_frame_drop         : one partial frame discarded this cycle
//   i_words_add          : number of input words discarded this cycle
//   o_frames_out         : frames emitted
//   o_frames_dropped     : partial frames discarded
//   o_words_discarded    : words discarded
// ----------------------------------------------------------------------------
module fso_framebuf_stats
   import fso_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_frame_out,
   input  logic        i_frame_drop,
   input  logic [31:0] i_words_add,
   output logic [31:0] o_frames_out,
   output logic [31:0] o_frames_dropped,
   output logic [31:0] o_words_discarded
);

   logic [31:0] r_frames_out;
   logic [31:0] r_frames_dropped;
   logic [31:0] r_words_discarded;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frames_out      <= '0;
         r_frames_dropped  <= '0;
         r_words_discarded <= '0;
      end else begin
         if (i_frame_out)  r_frames_out     <= r_frames_out + 32'd1;
         if (i_frame_drop) r_frames_dropped <= r_frames_dropped + 32'd1;
         r_words_discarded <= r_words_discarded + i_words_add;
      end
   end

   assign o_frames_out      = r_frames_out;
   assign o_frames_dropped  = r_frames_dropped;
   assign o_words_discarded = r_words_discarded;

endmodule : fso_framebuf_stats

// File: rtl/fso_payload_framebuf.sv
// ----------------------------------------------------------------------------
// fso_payload_framebuf
// Frame-granular ping-pong buffer behind the FSO deframer payload stream.
// Collects exactly PAYLOAD_WORDS words per frame into one of two register
// banks, drops runt/orphan fragments, and replays only complete frames with
// tlast on the final word. Two complete frames can be held at once.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_link_up           : link status; low flushes any partial frame
//   s_axis_*            : payload input (tuser[1]=frame_start, [0]=blk_soft_rst)
//   m_axis_*            : complete-frame output (tuser valid on word0 only)
//   o_frames_out        : frames emitted (wrapping)
//   o_frames_dropped    : partial frames discarded (wrapping)
//   o_words_discarded   : words discarded (wrapping)
//
// Build option: define FSO_FRAMEBUF_STATS_EN to build the three counters;
// otherwise the counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module fso_payload_framebuf
   import fso_pkg::*;
#(
   parameter int W             = 32,
   parameter int PAYLOAD_WORDS = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_link_up,
   input  logic [W-1:0] s_axis_tdata,
   input  logic [1:0]   s_axis_tuser,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   output logic [W-1:0] m_axis_tdata,
   output logic [1:0]   m_axis_tuser,
   output logic         m_axis_tlast,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [31:0]  o_frames_out,
   output logic [31:0]  o_frames_dropped,
   output logic [31:0]  o_words_discarded
);

   localparam int              CW       = $clog2(PAYLOAD_WORDS);
   localparam logic [CW-1:0]   LAST_IDX = CW'(PAYLOAD_WORDS - 1);

   // Storage and bank bookkeeping
   logic [W-1:0] r_mem [2][PAYLOAD_WORDS];
   logic [1:0]   r_full;
   logic [1:0]   r_blk;

   wr_state_t    r_wr_state;
   logic         r_wr_bank;
   logic [CW-1:0] r_wr_cnt;

   rd_state_t    r_rd_state;
   logic         r_rd_bank;
   logic [CW-1:0] r_rd_idx;

   // Combinational controls
   wr_state_t    w_wr_state_nxt;
   logic [CW-1:0] w_wr_cnt_nxt;
   logic [CW-1:0] w_wr_idx;
   logic         w_wr_we;
   logic         w_latch_blk;
   logic         w_commit;
   logic         w_drop;
   logic [CW-1:0] w_drop_words;
   logic         w_disc_word;
   rd_state_t    w_rd_state_nxt;
   logic [1:0]   w_m_tuser;

   logic w_s_ready, w_wr_fire, w_sof;
   logic w_m_valid, w_rd_fire, w_rd_last;
   logic w_cur_free, w_other_free;
   logic [31:0] w_words_add;

   assign w_s_ready = (r_wr_state != WR_WAIT);
   assign w_wr_fire = s_axis_tvalid & w_s_ready;
   assign w_sof     = s_axis_tuser[TUSER_SOF];

   // Valid follows the FULL flag directly so word0 appears the cycle after commit.
   assign w_m_valid = (r_rd_state == RD_DRAIN) | r_full[r_rd_bank];
   assign w_rd_fire = w_m_valid & m_axis_tready;
   assign w_rd_last = w_rd_fire & (r_rd_idx == LAST_IDX);

   // A bank released by the read side this cycle already counts as FREE.
   assign w_cur_free   = ~r_full[r_wr_bank]  | (w_rd_last & (r_rd_bank == r_wr_bank));
   assign w_other_free = ~r_full[~r_wr_bank] | (w_rd_last & (r_rd_bank != r_wr_bank));

   // Write FSM: next state and datapath strobes
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave one unassigned and infer a latch.
      w_wr_state_nxt = r_wr_state;
      w_wr_cnt_nxt   = r_wr_cnt;
      w_wr_idx       = r_wr_cnt;
      w_wr_we        = 1'b0;
      w_latch_blk    = 1'b0;
      w_commit       = 1'b0;
      w_drop         = 1'b0;
      w_drop_words   = '0;
      w_disc_word    = 1'b0;

      if (!i_link_up) begin
         // Link loss flushes any partial frame; words presented now are lost.
         w_wr_state_nxt = WR_HUNT;
         w_wr_cnt_nxt   = '0;
         if (r_wr_state == WR_FILL) begin
            w_drop       = 1'b1;
            w_drop_words = r_wr_cnt;
         end
         w_disc_word = w_wr_fire;
      end else begin
         case (r_wr_state)
            WR_HUNT: begin
               if (w_wr_fire) begin
                  if (w_sof) begin
                     w_wr_we        = 1'b1;
                     w_wr_idx       = '0;
                     w_latch_blk    = 1'b1;
                     w_wr_cnt_nxt   = CW'(1);
                     w_wr_state_nxt = WR_FILL;
                  end else begin
                     w_disc_word = 1'b1;
                  end
               end
            end
            WR_FILL: begin
               if (w_wr_fire) begin
                  w_wr_we = 1'b1;
                  if (w_sof) begin
                     // Runt restart: abandon fragment, new frame starts at word0.
                     w_drop       = 1'b1;
                     w_drop_words = r_wr_cnt;
                     w_wr_idx     = '0;
                     w_latch_blk  = 1'b1;
                     w_wr_cnt_nxt = CW'(1);
                  end else if (r_wr_cnt == LAST_IDX) begin
                     w_commit       = 1'b1;
                     w_wr_cnt_nxt   = '0;
                     w_wr_state_nxt = w_other_free ? WR_HUNT : WR_WAIT;
                  end else begin
                     w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                  end
               end
            end
            WR_WAIT: begin
               if (w_cur_free) w_wr_state_nxt = WR_HUNT;
            end
            default: w_wr_state_nxt = WR_HUNT;
         endcase
      end
   end

   // Read FSM: next state
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      case (r_rd_state)
         RD_IDLE:  if (r_full[r_rd_bank]) w_rd_state_nxt = RD_DRAIN;
         RD_DRAIN: if (w_rd_last)
                      w_rd_state_nxt = (r_full[~r_rd_bank] | w_commit) ? RD_DRAIN : RD_IDLE;
         default:  w_rd_state_nxt = RD_IDLE;
      endcase
   end

   // Control state
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_wr_state <= WR_HUNT;
         r_wr_bank  <= 1'b0;
         r_wr_cnt   <= '0;
         r_full     <= '0;
         r_blk      <= '0;
         r_rd_state <= RD_IDLE;
         r_rd_bank  <= 1'b0;
         r_rd_idx   <= '0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_wr_cnt   <= w_wr_cnt_nxt;
         r_rd_state <= w_rd_state_nxt;
         if (w_latch_blk) r_blk[r_wr_bank] <= s_axis_tuser[TUSER_BLK_RST];
         // Commit and drain always target opposite banks.
         if (w_commit) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
         end
         if (w_rd_fire) r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
         if (w_rd_last) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
         end
      end
   end

   // NOTE: the payload array is deliberately not reset; contents are only read
   // from a FULL bank, and output data is forced to zero while not valid.
   always_ff @(posedge clk) begin
      if (w_wr_we) r_mem[r_wr_bank][w_wr_idx] <= s_axis_tdata;
   end

   always_comb begin
      w_m_tuser = 2'b00;
      if (w_m_valid && (r_rd_idx == '0)) begin
         w_m_tuser[TUSER_SOF]     = 1'b1;
         w_m_tuser[TUSER_BLK_RST] = r_blk[r_rd_bank];
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tvalid = w_m_valid;
   assign m_axis_tdata  = w_m_valid ? r_mem[r_rd_bank][r_rd_idx] : '0;
   assign m_axis_tlast  = w_m_valid & (r_rd_idx == LAST_IDX);
   assign m_axis_tuser  = w_m_tuser;

   assign w_words_add = 32'(w_drop_words) + 32'(w_disc_word);

`ifdef FSO_FRAMEBUF_STATS_EN
   fso_framebuf_stats u_stats (
      .clk               (clk),
      .rst               (rst),
      .i_frame_out       (w_rd_last),
      .i_frame_drop      (w_drop),
      .i_words_add       (w_words_add),
      .o_frames_out      (o_frames_out),
      .o_frames_dropped  (o_frames_dropped),
      .o_words_discarded (o_words_discarded)
   );
`else
   assign o_frames_out      = '0;
   assign o_frames_dropped  = '0;
   assign o_words_discarded = '0;
   logic w_unused_stats;
   assign w_unused_stats = ^{w_drop, w_words_add};
`endif

endmodule : fso_payload_framebuf

// File: tb/tb_fso_payload_framebuf.sv
// ----------------------------------------------------------------------------
// tb_fso_payload_framebuf
// Directed self-checking bench for fso_payload_framebuf (W=32, 16 words/frame).
// Counter expectations collapse to zero when FSO_FRAMEBUF_STATS_EN is not set.
// ----------------------------------------------------------------------------
module tb_fso_payload_framebuf;

   localparam int W  = 32;
   localparam int PW = 16;
`ifdef FSO_FRAMEBUF_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_link_up;
   logic [W-1:0]  s_axis_tdata;
   logic [1:0]    s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic [1:0]    m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [31:0]   o_frames_out;
   logic [31:0]   o_frames_dropped;
   logic [31:0]   o_words_discarded;

   fso_payload_framebuf #(.W(W), .PAYLOAD_WORDS(PW)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_link_up         (i_link_up),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tuser      (s_axis_tuser),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tuser      (m_axis_tuser),
      .m_axis_tlast      (m_axis_tlast),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tready     (m_axis_tready),
      .o_frames_out      (o_frames_out),
      .o_frames_dropped  (o_frames_dropped),
      .o_words_discarded (o_words_discarded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cyc  = 0;

   // Output capture, sampled on the falling edge
   logic [31:0] q_data [$];
   logic [2:0]  q_ctl  [$];   // {tlast, tuser[1:0]}
   int          q_cyc  [$];

   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_ctl.push_back({m_axis_tlast, m_axis_tuser});
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat(input int v);
      return STATS_EN ? 32'(v) : 32'd0;
   endfunction

   task automatic clear_q();
      q_data.delete();
      q_ctl.delete();
      q_cyc.delete();
   endtask

   // Present one word and hold it until accepted (bounded).
   task automatic send_word(input logic [31:0] d, input logic [1:0] u);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_axis_tready) check("send_timeout", 32'(s_axis_tready), 32'd1);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] base, input logic blk);
      for (int i = 0; i < PW; i++)
         send_word(base + 32'(i), (i == 0) ? {1'b1, blk} : 2'b00);
   endtask

   // Compare captured frame k against base+i data with sof/blk on word0, tlast on word15.
   task automatic check_frame(input string tag, input int k, input logic [31:0] base,
                              input logic blk);
      int          j;
      logic [31:0] d;
      logic [2:0]  c;
      logic [2:0]  ce;
      for (int i = 0; i < PW; i++) begin
         j  = k * PW + i;
         d  = (j < q_data.size()) ? q_data[j] : 32'hFFFF_FFFF;
         c  = (j < q_ctl.size())  ? q_ctl[j]  : 3'b111;
         ce = {(i == PW - 1), (i == 0), (i == 0) & blk};
         check({tag, "_data"}, d, base + 32'(i));
         check({tag, "_ctl"}, 32'(c), 32'(ce));
      end
   endtask

   initial begin
      rst           = 1'b1;
      i_link_up     = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_axis_tready), 32'd1);
      check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
      check("rst_m_last",  32'(m_axis_tlast),  32'd0);
      check("rst_m_user",  32'(m_axis_tuser),  32'd0);
      check("rst_m_data",  m_axis_tdata,       32'd0);
      check("rst_fout",    o_frames_out,       32'd0);
      check("rst_fdrop",   o_frames_dropped,   32'd0);
      check("rst_wdisc",   o_words_discarded,  32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ---------------- two clean frames ----------------
      send_frame(32'h1000, 1'b0);
      begin
         int t_last0;
         t_last0 = acc_cyc;
         send_frame(32'h1010, 1'b0);
         repeat (24) @(negedge clk);
         check("t1_count", 32'(q_data.size()), 32'd32);
         check("t1_latency", 32'((q_cyc.size() > 0) ? q_cyc[0] : 0), 32'(t_last0 + 1));
         check("t1_no_bubble", 32'((q_cyc.size() > 16) ? q_cyc[16] - q_cyc[15] : 0), 32'd1);
      end
      check_frame("t1_f0", 0, 32'h1000, 1'b0);
      check_frame("t1_f1", 1, 32'h1010, 1'b0);
      check("t1_fout", o_frames_out, stat(2));
      clear_q();

      // ---------------- orphan words ----------------
      for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + 32'(i), 2'b00);
      send_frame(32'h2000, 1'b0);
      repeat (20) @(negedge clk);
      check("t2_count", 32'(q_data.size()), 32'd16);
      check_frame("t2_f", 0, 32'h2000, 1'b0);
      check("t2_wdisc", o_words_discarded, stat(5));
      check("t2_fout",  o_frames_out,      stat(3));
      clear_q();

      // ---------------- runt restart ----------------
      send_word(32'h3000, 2'b10);
      for (int i = 1; i < 8; i++) send_word(32'h3000 + 32'(i), 2'b00);
      send_frame(32'h4000, 1'b1);
      repeat (20) @(negedge clk);
      check("t3_count", 32'(q_data.size()), 32'd16);
      check_frame("t3_f", 0, 32'h4000, 1'b1);
      check("t3_fdrop", o_frames_dropped,  stat(1));
      check("t3_wdisc", o_words_discarded, stat(13));
      check("t3_fout",  o_frames_out,      stat(4));
      clear_q();

      // ---------------- backpressure ----------------
      m_axis_tready = 1'b0;
      send_frame(32'h5000, 1'b0);
      send_frame(32'h6000, 1'b0);
      @(negedge clk);
      check("t4_s_ready_low", 32'(s_axis_tready), 32'd0);
      s_axis_tdata  = 32'h7000;
      s_axis_tuser  = 2'b10;
      s_axis_tvalid = 1'b1;
      repeat (4) @(negedge clk);
      check("t4_s_ready_held", 32'(s_axis_tready), 32'd0);
      check("t4_m_valid_hold", 32'(m_axis_tvalid), 32'd1);
      check("t4_m_data_hold",  m_axis_tdata,       32'h5000);
      check("t4_m_user_hold",  32'(m_axis_tuser),  32'd2);
      @(posedge clk);
      #1 m_axis_tready = 1'b1;
      send_frame(32'h7000, 1'b0);
      repeat (40) @(negedge clk);
      check("t4_count", 32'(q_data.size()), 32'd48);
      check_frame("t4_fa", 0, 32'h5000, 1'b0);
      check_frame("t4_fb", 1, 32'h6000, 1'b0);
      check_frame("t4_fc", 2, 32'h7000, 1'b0);
      check("t4_fout", o_frames_out, stat(7));
      clear_q();

      // ---------------- link drop at word 9 ----------------
      send_word(32'hB000, 2'b10);
      for (int i = 1; i < 9; i++) send_word(32'hB000 + 32'(i), 2'b00);
      i_link_up = 1'b0;
      send_word(32'hB009, 2'b00);
      i_link_up = 1'b1;
      repeat (4) @(negedge clk);
      check("t5_no_output", 32'(q_data.size()), 32'd0);
      check("t5_fdrop", o_frames_dropped,  stat(2));
      check("t5_wdisc", o_words_discarded, stat(23));
      send_frame(32'hC000, 1'b0);
      repeat (20) @(negedge clk);
      check("t5_count", 32'(q_data.size()), 32'd16);
      check_frame("t5_f", 0, 32'hC000, 1'b0);
      check("t5_fout", o_frames_out, stat(8));
      clear_q();

      // ---------------- reset mid-drain ----------------
      m_axis_tready = 1'b0;
      send_frame(32'h9000, 1'b1);
      repeat (2) @(negedge clk);
      check("t6_full_valid", 32'(m_axis_tvalid), 32'd1);
      check("t6_full_user",  32'(m_axis_tuser),  32'd3);
      @(posedge clk);
      #1 m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      rst           = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_drained3",  32'(q_data.size()), 32'd3);
      check("t6_m_valid",   32'(m_axis_tvalid), 32'd0);
      check("t6_m_data",    m_axis_tdata,       32'd0);
      check("t6_m_user",    32'(m_axis_tuser),  32'd0);
      check("t6_m_last",    32'(m_axis_tlast),  32'd0);
      check("t6_s_ready",   32'(s_axis_tready), 32'd1);
      check("t6_fout",      o_frames_out,       32'd0);
      check("t6_fdrop",     o_frames_dropped,   32'd0);
      check("t6_wdisc",     o_words_discarded,  32'd0);
      clear_q();

      // Post-reset operation
      m_axis_tready = 1'b1;
      send_frame(32'hA000, 1'b0);
      repeat (20) @(negedge clk);
      check("t7_count", 32'(q_data.size()), 32'd16);
      check_frame("t7_f", 0, 32'hA000, 1'b0);
      check("t7_fout", o_frames_out, stat(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fso_payload_framebuf

// File: doc/fso_payload_framebuf.md
# fso_payload_framebuf

Frame-granular ping-pong buffer directly downstream of the FSO deframer's payload AXIS output. It collects exactly PAYLOAD_WORDS payload words per frame, discards runt or orphan fragments, and re-emits only complete frames with a `tlast` marker. The downstream consumer therefore never sees a partial frame. It decouples deframer timing from consumer backpressure by holding up to two complete frames.

## Interface
- `W`, 32: payload word width.
- `PAYLOAD_WORDS`, 16: words per frame; must be ≥2.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_link_up`  in  1  link status; low flushes the write side.
- `s_axis_tdata`  in  W  payload word from deframer.
- `s_axis_tuser`  in  2  [0] blk_soft_rst on word0, [1] frame_start on word0.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  W  buffered payload word.
- `m_axis_tuser`  out  2  [0] blk_soft_rst of the frame, [1] start-of-frame; both nonzero only on word0.
- `m_axis_tlast`  out  1  high on word PAYLOAD_WORDS-1.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `o_frames_out`  out  32  frames fully emitted; wraps.
- `o_frames_dropped`  out  32  partial frames discarded; wraps.
- `o_words_discarded`  out  32  words dropped while hunting or in dropped fragments; wraps.

## Operation
- Two banks of PAYLOAD_WORDS×W registers, plus a per-bank `blk_soft_rst` flag. Each bank is in one of two states: FREE or FULL.
- Write FSM:
  - HUNT: `s_axis_tready`=1. A word with tuser[1]=0 is discarded (`o_words_discarded`+1). A word with tuser[1]=1 is written to index 0 of the current write bank, its tuser[0] is latched, and the FSM moves to FILL with count=1.
  - FILL: each accepted word is written at index=count.
    - A word with tuser[1]=1 arriving while count≠0 is a runt restart. The fragment is dropped (`o_frames_dropped`+1, `o_words_discarded`+=count). The new word is written at index 0, count becomes 1, and the FSM stays in FILL.
    - When the word at count=PAYLOAD_WORDS-1 is accepted, the bank is marked FULL and the write pointer toggles.
    - If the new write bank is FREE, the FSM goes to HUNT. Otherwise it goes to WAIT.
  - WAIT: `s_axis_tready`=0. The FSM returns to HUNT in the cycle the target bank becomes FREE.
- `s_axis_tready` = (state≠WAIT).
- Read FSM: IDLE → DRAIN when the read bank is FULL.
  - `m_axis_tdata` = bank[rd_bank][rd_idx], muxed from the register array.
  - rd_idx advances on each `tvalid&tready`.
  - On the tlast handshake: the bank becomes FREE, rd_bank toggles, `o_frames_out`+1. The FSM goes to IDLE, or stays in DRAIN if the other bank is already FULL.
- `i_link_up`=0:
  - The write FSM is forced to HUNT, and any partial count is dropped (counted as a drop if count>0).
  - FULL banks continue to drain.
  - Input words presented while the link is down are discarded and counted.
- Simultaneous events:
  - Bank freed by the read side and claimed by the write side in the same cycle: the write side sees FREE, no stall.
  - Commit and drain of opposite banks in the same cycle: both proceed.

## Timing
- Reset: both banks FREE, write FSM HUNT, read FSM IDLE, all pointers 0.
- Reset values of outputs: `s_axis_tready`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0, all counters 0.
- Latency: last word accepted in cycle N → `m_axis_tvalid`=1 with word0 in cycle N+1 (if the read side is idle).
- Throughput is one word per cycle on both sides with no bubble between back-to-back frames.
- AXIS rules: once asserted, `m_axis_tvalid` and `m_axis_tdata` hold until the handshake completes. `tready` may toggle freely.
- Reset asserted mid-frame: the next cycle is identical to the post-reset state, and no counter increments for the aborted frame.

## Configuration
- `FSO_FRAMEBUF_STATS_EN` defined: the three 32-bit counters are implemented as specified.
- `FSO_FRAMEBUF_STATS_EN` not defined: the counters are not built, and `o_frames_out`, `o_frames_dropped` and `o_words_discarded` are tied to 0. Datapath behaviour is identical.

## Structure
- Shared package `fso_pkg` holds:
  - write-FSM state encoding (HUNT/FILL/WAIT);
  - read-FSM encoding (IDLE/DRAIN);
  - tuser bit-index constants (TUSER_BLK_RST=0, TUSER_SOF=1).
- Sub-module `fso_framebuf_stats` holds the three wrapping counters. Its instantiation is guarded by the macro.

## Test plan
- **Two clean frames:** with PAYLOAD_WORDS=16 and `m_axis_tready`=1, send two clean frames with data 0x1000+i. Required: 32 output words, tlast on words 15 and 31, `o_frames_out`=2, first output in the cycle after the 16th input.
- **Orphan words:** send 5 words with tuser=0, then a good frame. Required: 5 words discarded, `o_words_discarded`=5, frame emitted intact.
- **Runt restart:** send a frame_start followed by 7 words, then a new frame_start and 15 words. Required: `o_frames_dropped`=1, `o_words_discarded`=8, one clean frame out.
- **Backpressure:** hold `m_axis_tready`=0 and send 3 frames. Required: `s_axis_tready` falls after the 2nd frame is committed. Release tready: frames emerge in order, none lost, `o_frames_out`=3.
- **Link drop and reset:** deassert `i_link_up` at word 9, and pulse `rst` mid-drain of a FULL bank. Required: link drop gives `o_frames_dropped`+1. The reset gives `m_axis_tvalid`=0 on the next cycle and all counters 0.
